// File: rtl/multiplier32_seq.sv
// Sequential 32x32 -> 64 unsigned shift-and-add multiplier with start/busy/done handshake and abort.
// Latency: start accepted at E0, 32 EXEC edges, done pulses for one cycle after E32 (one product per 33 cycles).
// Backpressure: none; start is ignored while busy, abort cancels an in-flight multiply without a done pulse.
module multiplier32_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [63:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [64:0] acc_q, acc_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] result_q, result_d;

    logic [32:0] sum;
    logic [64:0] acc_shift;

    // acc_q[64] is always zero between steps, so folding it into the add is harmless.
    always_comb begin
        sum       = acc_q[64:32] + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
        acc_shift = {sum, acc_q[31:0]} >> 1;
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d = op_a;
                    acc_d   = {33'd0, op_b};
                    cnt_d   = 6'd0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_shift;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        result_d = acc_shift[63:0];
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Accepting start here gives back-to-back operation.
                if (start) begin
                    mcand_d = op_a;
                    acc_d   = {33'd0, op_b};
                    cnt_d   = 6'd0;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            mcand_q  <= 32'd0;
            acc_q    <= 65'd0;
            cnt_q    <= 6'd0;
            result_q <= 64'd0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == ST_EXEC);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_multiplier32_seq.sv
// Directed and random checks for multiplier32_seq: latency, handshake, back-to-back, abort and async reset.
module tb_multiplier32_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        abort;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t vt[10];

    multiplier32_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .abort   (abort),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
        end
    endtask

    // Starts one multiply and follows it to done. pulse_k >= 0 injects a stray
    // start (with other operands) into EXEC after edge pulse_k.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                           input string tag, input int pulse_k);
        int done_edge;
        int busy_cyc;
        int overlap;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        done_edge = -1;
        busy_cyc  = 0;
        overlap   = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) busy_cyc++;
            if (busy && done) overlap++;
            if (done) begin
                done_edge = k;
                break;
            end
            if (k == pulse_k) begin
                start = 1'b1;
                op_a  = 32'h0000_0063;
                op_b  = 32'h0000_0063;
            end else if (k == pulse_k + 1) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk({tag, "_done_edge"}, 64'(done_edge), 64'd32);
        chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'd32);
        chk({tag, "_result"}, result, exp);
        if (overlap != 0) chk({tag, "_busy_done_overlap"}, 64'(overlap), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int dc[2];
        logic [63:0] rc[2];
        int nd;
        int extra;
        logic [31:0] ra;
        logic [31:0] rb;

        n_chk  = 0;
        n_fail = 0;

        vt[0] = '{32'd3,          32'd5,          64'd15};
        vt[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
        vt[2] = '{32'd0,          32'h1234_5678,  64'd0};
        vt[3] = '{32'h1234_5678,  32'd0,          64'd0};
        vt[4] = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF};
        vt[5] = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE};
        vt[6] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
        vt[7] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};
        vt[8] = '{32'h1234_5678,  32'd9,          64'h0000_0000_A3D7_0A38};
        vt[9] = '{32'hDEAD_BEEF,  32'd1,          64'h0000_0000_DEAD_BEEF};

        reset_n = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        op_a    = 32'd0;
        op_b    = 32'd0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_result", result, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_mul(vt[i].a, vt[i].b, vt[i].p, $sformatf("vec%0d", i), -1);
        end

        // start held high: back-to-back products, op_a change lands in the second one.
        @(negedge clk);
        op_a  = 32'd7;
        op_b  = 32'd9;
        start = 1'b1;
        nd    = 0;
        dc[0] = -1;
        dc[1] = -1;
        rc[0] = '0;
        rc[1] = '0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (c == 10) op_a = 32'd2;
            if (done) begin
                if (nd < 2) begin
                    dc[nd] = c;
                    rc[nd] = result;
                end
                nd++;
                if (nd == 2) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        chk("b2b_done_count", 64'(nd), 64'd2);
        chk("b2b_first_edge", 64'(dc[0]), 64'd32);
        chk("b2b_interval", 64'(dc[1] - dc[0]), 64'd33);
        chk("b2b_first_result", rc[0], 64'd63);
        chk("b2b_second_result", rc[1], 64'd18);
        @(posedge clk);
        #1;
        chk("b2b_idle_after", {62'd0, busy, done}, 64'd0);

        // Abort mid-EXEC keeps the previous product and produces no done.
        run_mul(32'd6, 32'd7, 64'd42, "pre_abort", -1);
        @(negedge clk);
        op_a  = 32'd100;
        op_b  = 32'd100;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("abort_busy_before", {63'd0, busy}, 64'd1);
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy_after", {63'd0, busy}, 64'd0);
        chk("abort_done_after", {63'd0, done}, 64'd0);
        chk("abort_result_held", result, 64'd42);
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        chk("abort_no_done", 64'(extra), 64'd0);
        run_mul(32'd100, 32'd100, 64'd10000, "post_abort", -1);

        // abort in IDLE is ignored.
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_idle_result", result, 64'd10000);

        // Stray start during EXEC is ignored: one done, original operands.
        run_mul(32'd11, 32'd13, 64'd143, "stray_start", 5);
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        chk("stray_start_single_done", 64'(extra), 64'd0);

        // Asynchronous reset mid-EXEC.
        @(negedge clk);
        op_a  = 32'd5;
        op_b  = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        chk("async_rst_done", {63'd0, done}, 64'd0);
        chk("async_rst_result", result, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_idle", {62'd0, busy, done}, 64'd0);
        run_mul(32'd3, 32'd5, 64'd15, "post_rst", -1);

        // Random operands against a reference product.
        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) ra = 32'hFFFF_FFFF;
            run_mul(ra, rb, 64'(ra) * 64'(rb), $sformatf("rand%0d", i), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
